// File: rtl/game_pkg.sv
// Shared geometry, fixed-point format and ball state type for the game logic.
package game_pkg;
    localparam int FP_SHIFT  = 6;
    localparam int SCREEN_W  = 640;
    localparam int SCREEN_H  = 480;
    localparam int BALL_SIZE = 16;
    localparam int PADDLE_W  = 64;
    localparam int PADDLE_Y  = 440;

    localparam int LEFT   = 3;
    localparam int TOP    = 2;
    localparam int RIGHT  = 1;
    localparam int BOTTOM = 0;

    localparam int POS_W = 17;
    localparam int SPD_W = 11;

    typedef enum logic [1:0] {
        PARKED = 2'd0,
        MOVING = 2'd1,
        LOST   = 2'd2
    } ball_state_t;

    function automatic logic signed [POS_W-1:0] to_fp(input int pix);
        return POS_W'(pix * (1 << FP_SHIFT));
    endfunction
endpackage

// File: rtl/ball_move.sv
// Ball motion controller: parked on the paddle, launched, bounced off walls and
// objects once per frame, and re-parked after a loss delay.
//   state  | meaning
//   PARKED | ball rides the paddle, waits for a latched launch
//   MOVING | ball flies; reflect at frame start, step one cycle later
//   LOST   | ball fell below the screen; count frames before re-parking
module ball_move
    import game_pkg::*;
#(
    parameter int INIT_X_SPEED     = 120,
    parameter int INIT_Y_SPEED     = -180,
    parameter int LOST_WAIT_FRAMES = 60
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        launch,
    input  logic        collision,
    input  logic [3:0]  HitEdgeCode,
    input  logic [10:0] paddleX,
    output logic [10:0] topLeftX,
    output logic [10:0] topLeftY,
    output logic        moving,
    output logic        ballLost
);
    localparam int CNT_W = 16;
    // 312 is the parked X for a paddle at 288, i.e. roughly centred on screen.
    localparam logic signed [POS_W-1:0] RESET_X  = to_fp(312);
    localparam logic signed [POS_W-1:0] PARK_Y   = to_fp(PADDLE_Y - BALL_SIZE);
    localparam logic signed [POS_W-1:0] X_MAX    = to_fp(SCREEN_W - BALL_SIZE);
    localparam logic signed [POS_W-1:0] Y_LOST   = to_fp(SCREEN_H);
    localparam logic [10:0]             PARK_DX  = 11'(PADDLE_W / 2 - BALL_SIZE / 2);
    localparam logic signed [SPD_W-1:0] X_LAUNCH = SPD_W'(INIT_X_SPEED);
    localparam logic signed [SPD_W-1:0] Y_LAUNCH = SPD_W'(INIT_Y_SPEED);
    localparam logic [CNT_W-1:0]        WAIT_LD  = CNT_W'(LOST_WAIT_FRAMES);

    ball_state_t state, state_next;
    logic signed [POS_W-1:0] x_pos, y_pos, x_next, y_next, park_x, y_step;
    logic signed [SPD_W-1:0] x_spd, y_spd, x_spd_next, y_spd_next;
    logic [3:0]       hit, hit_next;
    logic             pending, pending_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             lost_next;
    logic             sof_d;
    logic             flip_x, flip_y;
    logic             x_neg, x_pos_dir, y_neg, y_pos_dir;

    assign park_x    = {paddleX + PARK_DX, {FP_SHIFT{1'b0}}};
    assign y_step    = y_pos + POS_W'(y_spd);
    assign x_neg     = x_spd[SPD_W-1];
    assign x_pos_dir = !x_spd[SPD_W-1] && (x_spd != '0);
    assign y_neg     = y_spd[SPD_W-1];
    assign y_pos_dir = !y_spd[SPD_W-1] && (y_spd != '0);

    always_comb begin
        state_next   = state;
        x_next       = x_pos;
        y_next       = y_pos;
        x_spd_next   = x_spd;
        y_spd_next   = y_spd;
        hit_next     = hit;
        pending_next = pending;
        cnt_next     = cnt;
        lost_next    = 1'b0;
        flip_x       = 1'b0;
        flip_y       = 1'b0;
        unique case (state)
            PARKED: begin
                x_spd_next = '0;
                y_spd_next = '0;
                hit_next   = '0;
                cnt_next   = '0;
                if (launch) pending_next = 1'b1;
                if (startOfFrame) begin
                    x_next = park_x;
                    y_next = PARK_Y;
                    if (pending) begin
                        state_next   = MOVING;
                        x_spd_next   = X_LAUNCH;
                        y_spd_next   = Y_LAUNCH;
                        pending_next = 1'b0;
                    end
                end
            end
            MOVING: begin
                pending_next = 1'b0;
                if (collision) hit_next = hit | HitEdgeCode;
                if (startOfFrame) begin
                    // One OR per axis, so a wall and an object on the same side flip once.
                    flip_x = (hit[LEFT] && x_neg) || (hit[RIGHT] && x_pos_dir)
                          || ((x_pos[POS_W-1] || x_pos == '0) && x_neg)
                          || ((x_pos >= X_MAX) && x_pos_dir);
                    flip_y = (hit[TOP] && y_neg) || (hit[BOTTOM] && y_pos_dir)
                          || ((y_pos[POS_W-1] || y_pos == '0) && y_neg);
                    if (flip_x) x_spd_next = -x_spd;
                    if (flip_y) y_spd_next = -y_spd;
                    hit_next = collision ? HitEdgeCode : 4'b0000;
                end else if (sof_d) begin
                    x_next = x_pos + POS_W'(x_spd);
                    y_next = y_step;
                    if (y_step >= Y_LOST) begin
                        state_next = LOST;
                        lost_next  = 1'b1;
                        x_spd_next = '0;
                        y_spd_next = '0;
                        cnt_next   = WAIT_LD;
                    end
                end
            end
            LOST: begin
                pending_next = 1'b0;
                hit_next     = '0;
                if (startOfFrame) begin
                    if (cnt <= CNT_W'(1)) begin
                        state_next = PARKED;
                        cnt_next   = '0;
                        x_next     = park_x;
                        y_next     = PARK_Y;
                    end else begin
                        cnt_next = cnt - CNT_W'(1);
                    end
                end
            end
            default: state_next = PARKED;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) state <= PARKED;
        else         state <= state_next;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            x_pos    <= RESET_X;
            y_pos    <= PARK_Y;
            x_spd    <= '0;
            y_spd    <= '0;
            hit      <= '0;
            pending  <= 1'b0;
            cnt      <= '0;
            ballLost <= 1'b0;
            sof_d    <= 1'b0;
        end else begin
            x_pos    <= x_next;
            y_pos    <= y_next;
            x_spd    <= x_spd_next;
            y_spd    <= y_spd_next;
            hit      <= hit_next;
            pending  <= pending_next;
            cnt      <= cnt_next;
            ballLost <= lost_next;
            sof_d    <= startOfFrame;
        end
    end

    assign topLeftX = x_pos[POS_W-1:FP_SHIFT];
    assign topLeftY = y_pos[POS_W-1:FP_SHIFT];
    assign moving   = (state == MOVING);
endmodule
